// File: rtl/watch_pkg.sv
// Shared types and constants for the countdown timer bank.
// Holds the channel-state and command enums, the time payload and the time helpers.
package watch_pkg;

    localparam int unsigned MIN_W    = 7;
    localparam int unsigned SEC_W    = 7;
    localparam int unsigned MSEC_W   = 10;
    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MSEC_MAX = 999;
    localparam int unsigned BTN_W    = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_RING  = 2'd3
    } ch_state_e;

    typedef enum logic [2:0] {
        CMD_NONE       = 3'd0,
        CMD_ZERO       = 3'd1,
        CMD_ACK        = 3'd2,
        CMD_START_STOP = 3'd3,
        CMD_INC_MIN    = 3'd4,
        CMD_DEC_MIN    = 3'd5,
        CMD_INC_SEC    = 3'd6,
        CMD_DEC_SEC    = 3'd7
    } cmd_e;

    typedef struct packed {
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } time_t;

    function automatic logic time_is_zero(input time_t t);
        return (t == '0);
    endfunction

    // One-millisecond decrement with msec->sec->min borrow; caller guarantees t != 0.
    function automatic time_t time_dec(input time_t t);
        time_t r;
        r = t;
        if (t.msec != '0) begin
            r.msec = t.msec - MSEC_W'(1);
        end else begin
            r.msec = MSEC_W'(MSEC_MAX);
            if (t.sec != '0) begin
                r.sec = t.sec - SEC_W'(1);
            end else begin
                r.sec = SEC_W'(SEC_MAX);
                r.min = t.min - MIN_W'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: state, remaining time, ring counter and adjust/decrement logic.
// Commands arrive already decoded and gated to this channel; i_tick is the shared ms strobe.
module timer_channel
    import watch_pkg::*;
#(
    parameter int unsigned MAX_MIN = 99,
    parameter int unsigned RING_MS = 10000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_tick,
    input  cmd_e      i_cmd,
    output ch_state_e o_state,
    output time_t     o_time
);

    localparam int unsigned RC_W = (RING_MS > 1) ? $clog2(RING_MS) : 1;

    ch_state_e       r_state;
    time_t           r_time;
    logic [RC_W-1:0] r_ring_cnt;

    ch_state_e       w_state_nxt;
    time_t           w_time_nxt;
    logic [RC_W-1:0] w_ring_cnt_nxt;
    time_t           w_adj;
    time_t           w_dec;
    logic            w_is_adj;
    logic            w_zero;
    logic            w_silence;

    assign w_dec     = time_dec(r_time);
    assign w_zero    = time_is_zero(r_time);
    assign w_silence = (i_cmd == CMD_ZERO) || (i_cmd == CMD_ACK) || (i_cmd == CMD_START_STOP);

    // Adjusted time for the four set commands; fields wrap independently, msec always cleared.
    always_comb begin
        w_adj      = r_time;
        w_adj.msec = '0;
        w_is_adj   = 1'b1;
        case (i_cmd)
            CMD_INC_MIN: w_adj.min = (r_time.min >= MIN_W'(MAX_MIN)) ? '0 : r_time.min + MIN_W'(1);
            CMD_DEC_MIN: w_adj.min = (r_time.min == '0) ? MIN_W'(MAX_MIN) : r_time.min - MIN_W'(1);
            CMD_INC_SEC: w_adj.sec = (r_time.sec >= SEC_W'(SEC_MAX)) ? '0 : r_time.sec + SEC_W'(1);
            CMD_DEC_SEC: w_adj.sec = (r_time.sec == '0) ? SEC_W'(SEC_MAX) : r_time.sec - SEC_W'(1);
            default: begin
                w_adj    = r_time;
                w_is_adj = 1'b0;
            end
        endcase
    end

    // Next-state logic; a command in RUN takes precedence over that cycle's tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_time_nxt     = r_time;
        w_ring_cnt_nxt = r_ring_cnt;
        case (r_state)
            ST_IDLE, ST_PAUSE: begin
                if (i_cmd == CMD_ZERO) begin
                    w_state_nxt = ST_IDLE;
                    w_time_nxt  = '0;
                end else if (i_cmd == CMD_START_STOP) begin
                    if (!w_zero) begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (w_is_adj) begin
                    w_time_nxt = w_adj;
                end
            end
            ST_RUN: begin
                if (i_cmd == CMD_ZERO) begin
                    w_state_nxt = ST_IDLE;
                    w_time_nxt  = '0;
                end else if (i_cmd == CMD_START_STOP) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_zero) begin
                    w_state_nxt    = ST_RING;
                    w_ring_cnt_nxt = '0;
                end else if (i_tick) begin
                    w_time_nxt = w_dec;
                    if (time_is_zero(w_dec)) begin
                        w_state_nxt    = ST_RING;
                        w_ring_cnt_nxt = '0;
                    end
                end
            end
            ST_RING: begin
                if (w_silence) begin
                    w_state_nxt    = ST_IDLE;
                    w_time_nxt     = '0;
                    w_ring_cnt_nxt = '0;
                end else if (i_tick) begin
                    if (r_ring_cnt == RC_W'(RING_MS - 1)) begin
                        w_state_nxt    = ST_IDLE;
                        w_time_nxt     = '0;
                        w_ring_cnt_nxt = '0;
                    end else begin
                        w_ring_cnt_nxt = r_ring_cnt + RC_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_time_nxt     = '0;
                w_ring_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_time     <= '0;
            r_ring_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_time     <= w_time_nxt;
            r_ring_cnt <= w_ring_cnt_nxt;
        end
    end

    assign o_state = r_state;
    assign o_time  = r_time;

endmodule

// File: rtl/timer_bank.sv
// Bank of N_CH independent countdown timers sharing a ms prescaler and one button set.
// Buttons are edge-detected, priority-decoded and steered to the channel picked by sel.
module timer_bank
    import watch_pkg::*;
#(
    parameter  int unsigned N_CH       = 4,
    parameter  int unsigned CLK_PER_MS = 1,
    parameter  int unsigned MAX_MIN    = 99,
    parameter  int unsigned RING_MS    = 10000,
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_W-1:0]   sel,
    input  logic              start_stop,
    input  logic              zero,
    input  logic              inc_min,
    input  logic              dec_min,
    input  logic              inc_sec,
    input  logic              dec_sec,
    input  logic              ack,
    output logic [MIN_W-1:0]  disp_min,
    output logic [SEC_W-1:0]  disp_sec,
    output logic [MSEC_W-1:0] disp_msec,
    output logic [N_CH-1:0]   running,
    output logic [N_CH-1:0]   expired,
    output logic              ring
);

    localparam int unsigned PRE_W  = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int unsigned N_SLOT = 2 ** CH_W;

    logic [PRE_W-1:0] r_pre;
    logic             w_tick;
    logic [BTN_W-1:0] r_btn_q;
    logic [BTN_W-1:0] w_btn;
    logic [BTN_W-1:0] w_rise;
    cmd_e             w_cmd;
    time_t            w_times [N_SLOT];
    ch_state_e        w_states [N_CH];
    time_t            w_sel_time;

    // Shared millisecond strobe.
    assign w_tick = (r_pre == PRE_W'(CLK_PER_MS - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Bit order is also decode priority, highest at bit 0.
    assign w_btn  = {dec_sec, inc_sec, dec_min, inc_min, start_stop, ack, zero};
    assign w_rise = w_btn & ~r_btn_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_btn_q <= '0;
        end else begin
            r_btn_q <= w_btn;
        end
    end

    always_comb begin
        w_cmd = CMD_NONE;
        if (w_rise[0]) begin
            w_cmd = CMD_ZERO;
        end else if (w_rise[1]) begin
            w_cmd = CMD_ACK;
        end else if (w_rise[2]) begin
            w_cmd = CMD_START_STOP;
        end else if (w_rise[3]) begin
            w_cmd = CMD_INC_MIN;
        end else if (w_rise[4]) begin
            w_cmd = CMD_DEC_MIN;
        end else if (w_rise[5]) begin
            w_cmd = CMD_INC_SEC;
        end else if (w_rise[6]) begin
            w_cmd = CMD_DEC_SEC;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        cmd_e w_ch_cmd;

        assign w_ch_cmd = (sel == CH_W'(i)) ? w_cmd : CMD_NONE;

        timer_channel #(
            .MAX_MIN (MAX_MIN),
            .RING_MS (RING_MS)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_tick  (w_tick),
            .i_cmd   (w_ch_cmd),
            .o_state (w_states[i]),
            .o_time  (w_times[i])
        );

        assign running[i] = (w_states[i] == ST_RUN);
        assign expired[i] = (w_states[i] == ST_RING);
    end

    // Unpopulated sel codes display zero.
    for (genvar j = N_CH; j < N_SLOT; j++) begin : g_pad
        assign w_times[j] = '0;
    end

    assign w_sel_time = w_times[sel];
    assign disp_min   = w_sel_time.min;
    assign disp_sec   = w_sel_time.sec;
    assign disp_msec  = w_sel_time.msec;
    assign ring       = |expired;

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank (N_CH=4, CLK_PER_MS=1, defaults otherwise).
// A vector table covers set/priority behaviour; hand sequences cover run, ring and reset timing.
module tb_timer_bank;

    localparam logic [6:0] B_NONE = 7'b0000000;
    localparam logic [6:0] B_ZERO = 7'b0000001;
    localparam logic [6:0] B_ACK  = 7'b0000010;
    localparam logic [6:0] B_SS   = 7'b0000100;
    localparam logic [6:0] B_IMIN = 7'b0001000;
    localparam logic [6:0] B_DMIN = 7'b0010000;
    localparam logic [6:0] B_ISEC = 7'b0100000;
    localparam logic [6:0] B_DSEC = 7'b1000000;

    typedef struct {
        logic [1:0] sel;
        logic [6:0] btn;
        logic [6:0] m;
        logic [6:0] s;
        logic [9:0] ms;
        logic [3:0] run;
        logic [3:0] exp_;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       start_stop, zero, inc_min, dec_min, inc_sec, dec_sec, ack;
    logic [6:0] disp_min;
    logic [6:0] disp_sec;
    logic [9:0] disp_msec;
    logic [3:0] running;
    logic [3:0] expired;
    logic       ring;

    int n_chk = 0;
    int n_err = 0;
    vec_t tbl [13];

    timer_bank #(
        .N_CH       (4),
        .CLK_PER_MS (1),
        .MAX_MIN    (99),
        .RING_MS    (10000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .start_stop (start_stop),
        .zero       (zero),
        .inc_min    (inc_min),
        .dec_min    (dec_min),
        .inc_sec    (inc_sec),
        .dec_sec    (dec_sec),
        .ack        (ack),
        .disp_min   (disp_min),
        .disp_sec   (disp_sec),
        .disp_msec  (disp_msec),
        .running    (running),
        .expired    (expired),
        .ring       (ring)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) step();
    endtask

    task automatic press(input logic [1:0] s, input logic [6:0] b);
        sel = s;
        {dec_sec, inc_sec, dec_min, inc_min, start_stop, ack, zero} = b;
        step();
    endtask

    task automatic check(input string name, input logic [6:0] em, input logic [6:0] es,
                         input logic [9:0] ems, input logic [3:0] er, input logic [3:0] ee);
        logic [32:0] got;
        logic [32:0] want;
        got  = {disp_min, disp_sec, disp_msec, running, expired, ring};
        want = {em, es, ems, er, ee, |ee};
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d:%0d.%0d run=%b exp=%b ring=%b, want %0d:%0d.%0d run=%b exp=%b ring=%b",
                     name, disp_min, disp_sec, disp_msec, running, expired, ring,
                     em, es, ems, er, ee, |ee);
        end
    endtask

    initial begin
        // sel, buttons, expected min, sec, msec, running, expired (all in IDLE, no ticking)
        tbl[0]  = '{2'd2, B_ISEC,          7'd0,  7'd1,  10'd0, 4'b0000, 4'b0000};
        tbl[1]  = '{2'd2, B_ISEC,          7'd0,  7'd2,  10'd0, 4'b0000, 4'b0000};
        tbl[2]  = '{2'd2, B_ISEC,          7'd0,  7'd3,  10'd0, 4'b0000, 4'b0000};
        tbl[3]  = '{2'd1, B_NONE,          7'd0,  7'd0,  10'd0, 4'b0000, 4'b0000};
        tbl[4]  = '{2'd1, B_DMIN,          7'd99, 7'd0,  10'd0, 4'b0000, 4'b0000};
        tbl[5]  = '{2'd1, B_DSEC,          7'd99, 7'd59, 10'd0, 4'b0000, 4'b0000};
        tbl[6]  = '{2'd1, B_ISEC,          7'd99, 7'd0,  10'd0, 4'b0000, 4'b0000};
        tbl[7]  = '{2'd1, B_IMIN,          7'd0,  7'd0,  10'd0, 4'b0000, 4'b0000};
        tbl[8]  = '{2'd1, B_IMIN | B_DMIN, 7'd1,  7'd0,  10'd0, 4'b0000, 4'b0000};
        tbl[9]  = '{2'd1, B_DSEC | B_ISEC, 7'd1,  7'd1,  10'd0, 4'b0000, 4'b0000};
        tbl[10] = '{2'd1, B_ZERO | B_IMIN, 7'd0,  7'd0,  10'd0, 4'b0000, 4'b0000};
        tbl[11] = '{2'd3, B_SS,            7'd0,  7'd0,  10'd0, 4'b0000, 4'b0000};
        tbl[12] = '{2'd2, B_NONE,          7'd0,  7'd3,  10'd0, 4'b0000, 4'b0000};

        rst = 1'b0;
        sel = 2'd0;
        {dec_sec, inc_sec, dec_min, inc_min, start_stop, ack, zero} = B_NONE;
        wait_cyc(3);
        check("reset", 0, 0, 0, 4'b0000, 4'b0000);
        rst = 1'b1;
        step();
        check("post_reset", 0, 0, 0, 4'b0000, 4'b0000);

        for (int i = 0; i < 13; i++) begin
            press(tbl[i].sel, tbl[i].btn);
            check($sformatf("vec%0d", i), tbl[i].m, tbl[i].s, tbl[i].ms, tbl[i].run, tbl[i].exp_);
            press(tbl[i].sel, B_NONE);
        end

        // ch2 from 0:03.000 to expiry, then auto-silence after RING_MS ticks
        press(2, B_SS);
        check("a_start", 0, 3, 0, 4'b0100, 4'b0000);
        press(2, B_NONE);
        wait_cyc(999);
        check("a_2s", 0, 2, 0, 4'b0100, 4'b0000);
        step();
        check("a_borrow", 0, 1, 999, 4'b0100, 4'b0000);
        wait_cyc(1998);
        check("a_last_ms", 0, 0, 1, 4'b0100, 4'b0000);
        step();
        check("a_expire", 0, 0, 0, 4'b0000, 4'b0100);
        wait_cyc(9999);
        check("a_ring_hold", 0, 0, 0, 4'b0000, 4'b0100);
        step();
        check("a_auto_silence", 0, 0, 0, 4'b0000, 4'b0000);

        // held button on another channel, adjust ignored in RUN, one toggle per press
        press(0, B_IMIN);
        check("b_set", 1, 0, 0, 4'b0000, 4'b0000);
        press(0, B_NONE);
        press(0, B_SS);
        check("b_start", 1, 0, 0, 4'b0001, 4'b0000);
        press(0, B_IMIN);
        check("b_inc_in_run", 0, 59, 999, 4'b0001, 4'b0000);
        press(1, B_SS);
        wait_cyc(49);
        check("b_ch1_unchanged", 0, 0, 0, 4'b0001, 4'b0000);
        press(0, B_SS);
        check("b_ch0_counting", 0, 59, 948, 4'b0001, 4'b0000);
        press(0, B_NONE);
        press(0, B_SS);
        wait_cyc(9);
        check("b_single_pause", 0, 59, 947, 4'b0000, 4'b0000);
        press(0, B_ZERO);
        check("b_zero", 0, 0, 0, 4'b0000, 4'b0000);
        press(0, B_NONE);

        // pause on the tick that would have expired the channel
        press(0, B_ISEC);
        check("c_set", 0, 1, 0, 4'b0000, 4'b0000);
        press(0, B_NONE);
        press(0, B_SS);
        press(0, B_NONE);
        wait_cyc(998);
        check("c_one_ms", 0, 0, 1, 4'b0001, 4'b0000);
        press(0, B_SS);
        check("c_pause_on_tick", 0, 0, 1, 4'b0000, 4'b0000);
        press(0, B_NONE);
        check("c_frozen", 0, 0, 1, 4'b0000, 4'b0000);
        press(0, B_SS);
        check("c_resume", 0, 0, 1, 4'b0001, 4'b0000);
        press(0, B_NONE);
        check("c_ring", 0, 0, 0, 4'b0000, 4'b0001);
        press(0, B_ACK);
        check("c_ack", 0, 0, 0, 4'b0000, 4'b0000);
        press(0, B_NONE);

        // ch0 and ch3 expire on the same tick, silenced one at a time
        press(3, B_ISEC);
        press(3, B_NONE);
        check("d_ch3_set", 0, 1, 0, 4'b0000, 4'b0000);
        press(0, B_ISEC);
        press(0, B_NONE);
        press(0, B_ISEC);
        check("d_ch0_set", 0, 2, 0, 4'b0000, 4'b0000);
        press(0, B_NONE);
        press(0, B_SS);
        press(0, B_NONE);
        wait_cyc(998);
        press(3, B_SS);
        check("d_both_run", 0, 1, 0, 4'b1001, 4'b0000);
        press(3, B_NONE);
        wait_cyc(998);
        check("d_before", 0, 0, 1, 4'b1001, 4'b0000);
        step();
        check("d_both_expire", 0, 0, 0, 4'b0000, 4'b1001);
        press(0, B_ACK);
        check("d_ack0", 0, 0, 0, 4'b0000, 4'b1000);
        press(0, B_NONE);
        press(3, B_ACK);
        check("d_ack3", 0, 0, 0, 4'b0000, 4'b0000);
        press(3, B_NONE);

        // reset with one channel running and another ringing
        press(2, B_ISEC);
        press(2, B_NONE);
        press(2, B_SS);
        press(1, B_IMIN);
        press(1, B_NONE);
        press(1, B_SS);
        check("e_run", 1, 0, 0, 4'b0110, 4'b0000);
        press(1, B_NONE);
        wait_cyc(1000);
        check("e_mixed", 0, 58, 999, 4'b0010, 4'b0100);
        rst = 1'b0;
        step();
        check("e_reset", 0, 0, 0, 4'b0000, 4'b0000);
        rst = 1'b1;
        step();
        check("e_after_reset", 0, 0, 0, 4'b0000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter N_CH, default 4, number of independent countdown channels (1..8).
REQ-002 Parameter CLK_PER_MS, default 1, clk cycles per millisecond tick (1 = 1 kHz clk).
REQ-003 Parameter MAX_MIN, default 99, largest settable minute value.
REQ-004 Parameter RING_MS, default 10000, auto-silence timeout in ms.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 sel  in  CH_W=max(1,clog2(N_CH))  channel targeted by commands and display.
REQ-008 start_stop, zero, inc_min, dec_min, inc_sec, dec_sec, ack  in  1 each  level button inputs, acted on at rising edge only.
REQ-009 disp_min  out  7; disp_sec  out  7; disp_msec  out  10  remaining time of channel sel.
REQ-010 running  out  N_CH  bit i high while channel i in RUN.
REQ-011 expired  out  N_CH  bit i high while channel i in RING.
REQ-012 ring  out  1  OR of expired; drives led/piezo.

Function
REQ-013 Internal prescaler shall assert a one-cycle ms tick every CLK_PER_MS cycles, shared by all channels.
REQ-014 Each button input shall be edge-detected against its previous-cycle value; a held button shall produce exactly one command.
REQ-015 Per cycle at most one command shall execute, on channel sel only, priority zero > ack > start_stop > inc_min > dec_min > inc_sec > dec_sec.
REQ-016 Channel states: IDLE, RUN, PAUSE, RING; reset state IDLE, time 0:00.000.
REQ-017 IDLE: start_stop with nonzero time -> RUN; with time 0:00.000 -> no change.
REQ-018 RUN: each tick decrements time; msec 0 -> 999 with sec borrow; sec 0 -> 59 with min borrow.
REQ-019 RUN: the tick that makes time 0:00.000 shall move the channel to RING on the next cycle, ring counter cleared.
REQ-020 RUN: start_stop -> PAUSE; that cycle's tick, if any, not applied.
REQ-021 PAUSE: start_stop -> RUN if time nonzero; time frozen otherwise.
REQ-022 RING: ring counter increments per tick; ack, start_stop, zero, or counter reaching RING_MS-1 -> IDLE, time 0:00.000.
REQ-023 zero in IDLE/PAUSE/RUN -> IDLE, time 0:00.000.
REQ-024 Adjust commands accepted only in IDLE and PAUSE, ignored in RUN and RING.
REQ-025 inc_min wraps MAX_MIN -> 0; dec_min wraps 0 -> MAX_MIN; inc_sec wraps 59 -> 0, dec_sec wraps 0 -> 59, no carry into minutes; any accepted adjust sets msec to 0.
REQ-026 Channels not selected shall keep counting/ringing unaffected by commands; changing sel mid-run has no effect on any channel.
REQ-027 sel >= N_CH: commands ignored, disp outputs 0.
REQ-028 disp_*, running, expired, ring shall be combinational from channel registers, reflecting a command the cycle after its edge is sampled.
REQ-029 Simultaneous expiry on several channels: each enters RING independently; ring stays high until all are silenced.

Reset
REQ-030 While rst low at a clk edge: all channels IDLE, time 0, ring counters 0, prescaler 0, edge-detect history 0.
REQ-031 Reset mid-RUN or mid-RING shall clear ring and running on the following cycle with no residual tick.
REQ-032 Outputs after reset: disp_* 0, running 0, expired 0, ring 0.

Structure
REQ-033 Shared package watch_pkg shall hold the channel-state enum, SEC_MAX=59, MSEC_MAX=999, and time field widths 7/7/10.
REQ-034 One sub-module timer_channel (state, time, ring counter, decrement/adjust logic) shall be instantiated N_CH times via generate; prescaler, edge detect, command decode, output mux stay in timer_bank.

Verification (N_CH=4, CLK_PER_MS=1)
REQ-035 sel=2, inc_sec x3, start_stop -> running=4'b0100; after 3000 ticks expired[2]=1, ring=1; disp 0:00.000.
REQ-036 Ringing channel 2, no ack -> ring drops exactly RING_MS ticks after entering RING; state IDLE.
REQ-037 ch0 set 1:00.000 running; sel=1, start_stop held 50 cycles -> ch1 unchanged (time 0), ch0 keeps counting; single command only.
REQ-038 dec_min at 0 -> 99; inc_sec at 59 -> 0, min unchanged; inc_min during RUN -> ignored.
REQ-039 ch0 at 0:00.001 RUN, start_stop coincident with tick -> PAUSE, disp 0:00.001, no RING.
REQ-040 ch0 and ch3 expire same tick; ack on sel=0 -> expired=4'b1000, ring=1; ack sel=3 -> ring=0; rst low mid-run -> all outputs 0 next cycle.
